// File: rtl/adc_burst_pkg.sv
// ----------------------------------------------------------------------------
// adc_burst_pkg
// Shared definitions for the ADC burst readout path.
//   state_e        : readout FSM states
//   HEADER_MAGIC   : top byte of the first header word
//   SAMPLE_SLOT_W  : bit width of one sample slot in a FIFO burst word
//   DEF_CNT_W      : default width of the burst-count fields
//   DEF_FILL_W     : default width of the fill-number field
// ----------------------------------------------------------------------------
package adc_burst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        LOAD,
        PAYLOAD,
        TRAILER,
        DONE
    } state_e;

    localparam logic [7:0]  HEADER_MAGIC  = 8'hA5;
    localparam int unsigned SAMPLE_SLOT_W = 16;
    localparam int unsigned DEF_CNT_W     = 21;
    localparam int unsigned DEF_FILL_W    = 24;

endpackage

// File: rtl/adc_burst_remaining_cntr.sv
// ----------------------------------------------------------------------------
// adc_burst_remaining_cntr
// Loadable down-counter tracking bursts still to be popped from the FIFO.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_load         : load i_load_val (has priority over i_dec)
//   i_load_val     : value to load
//   i_dec          : decrement request; ignored when the count is zero
//   o_count        : current count
//   o_at_zero      : registered flag, high whenever o_count is zero
// ----------------------------------------------------------------------------
module adc_burst_remaining_cntr
    import adc_burst_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_zero
);

    logic [CNT_W-1:0] r_count;
    logic             r_at_zero;

    // The zero flag is computed alongside the count update so it is a plain
    // flop output rather than a wide compare on the consumer side.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_at_zero <= 1'b1;
        end else if (i_load) begin
            r_count   <= i_load_val;
            r_at_zero <= (i_load_val == '0);
        end else if (i_dec && !r_at_zero) begin
            r_count   <= r_count - 1'b1;
            r_at_zero <= (r_count == CNT_W'(1));
        end
    end

    assign o_count   = r_count;
    assign o_at_zero = r_at_zero;

endmodule

// File: rtl/adc_burst_reader.sv
// ----------------------------------------------------------------------------
// adc_burst_reader
// Drains a first-word-fall-through burst FIFO after a fill and streams a
// frame of 32-bit words: {A5, fill_num}, {0, num_fill_bursts}, then each
// burst's samples packed two per word (odd sample in the upper half).
// Optional trailer: define ADC_BURST_READER_CHECKSUM_EN to append a word
// holding the modulo-2^32 sum of all header and payload words; out_last
// then marks the trailer.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : readout request pulse, honoured only when idle
//   num_fill_bursts       : bursts to read (latched on accepted start)
//   fill_num              : fill number for the header (latched on start)
//   fifo_data, fifo_empty : FWFT FIFO head word and empty flag
//   fifo_rd_en            : pop strobe
//   out_data/valid/ready/last : valid/ready word stream
//   busy, done            : readout in progress / end-of-readout pulse
//   bursts_left           : bursts not yet popped
// ----------------------------------------------------------------------------
module adc_burst_reader
    import adc_burst_pkg::*;
#(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned FILL_W    = DEF_FILL_W
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic [CNT_W-1:0]                   num_fill_bursts,
    input  logic [FILL_W-1:0]                  fill_num,
    input  logic [SAMPLE_SLOT_W*BURST_LEN-1:0] fifo_data,
    input  logic                               fifo_empty,
    output logic                               fifo_rd_en,
    output logic [31:0]                        out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_last,
    output logic                               busy,
    output logic                               done,
    output logic [CNT_W-1:0]                   bursts_left
);

    localparam int unsigned BURST_W = SAMPLE_SLOT_W * BURST_LEN;
    localparam int unsigned WORDS   = BURST_LEN / 2;
    localparam int unsigned IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e              r_state;
    logic [CNT_W-1:0]    r_nbursts;
    logic [BURST_W-1:0]  r_shift;
    logic [IDX_W-1:0]    r_widx;
    logic [31:0]         r_out_data;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_busy;
    logic                r_done;
`ifdef ADC_BURST_READER_CHECKSUM_EN
    logic [31:0]         r_sum;
`endif

    logic                w_xfer;
    logic                w_start_acc;
    logic                w_pop;
    logic                w_at_zero;
    logic [CNT_W-1:0]    w_count;

    assign w_xfer      = r_out_valid && out_ready;
    assign w_start_acc = (r_state == IDLE) && start;
    // Pop is combinational so the strobe coincides with the capture cycle.
    assign w_pop       = (r_state == LOAD) && !fifo_empty;

    adc_burst_remaining_cntr #(
        .CNT_W (CNT_W)
    ) u_remaining_cntr (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_start_acc),
        .i_load_val (num_fill_bursts),
        .i_dec      (w_pop),
        .o_count    (w_count),
        .o_at_zero  (w_at_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_nbursts   <= '0;
            r_shift     <= '0;
            r_widx      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_nbursts   <= num_fill_bursts;
                        // The output register itself holds the latched fill number.
                        r_out_data  <= {HEADER_MAGIC, fill_num};
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= HDR0;
                    end
                end

                HDR0: begin
                    if (w_xfer) begin
                        r_out_data <= {{(32-CNT_W){1'b0}}, r_nbursts};
`ifdef ADC_BURST_READER_CHECKSUM_EN
                        r_out_last <= 1'b0;
`else
                        r_out_last <= (r_nbursts == '0);
`endif
                        r_state    <= HDR1;
                    end
                end

                HDR1: begin
                    if (w_xfer) begin
                        if (w_at_zero) begin
`ifdef ADC_BURST_READER_CHECKSUM_EN
                            r_out_data  <= r_sum + r_out_data;
                            r_out_last  <= 1'b1;
                            r_state     <= TRAILER;
`else
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
`endif
                        end else begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_state     <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (!fifo_empty) begin
                        r_shift     <= {32'b0, fifo_data[BURST_W-1:32]};
                        r_out_data  <= fifo_data[31:0];
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_widx      <= '0;
                        r_state     <= PAYLOAD;
                    end
                end

                PAYLOAD: begin
                    if (w_xfer) begin
                        if (r_widx == LAST_IDX) begin
                            if (w_at_zero) begin
`ifdef ADC_BURST_READER_CHECKSUM_EN
                                r_out_data  <= r_sum + r_out_data;
                                r_out_last  <= 1'b1;
                                r_state     <= TRAILER;
`else
                                r_out_valid <= 1'b0;
                                r_out_last  <= 1'b0;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= DONE;
`endif
                            end else begin
                                r_out_valid <= 1'b0;
                                r_state     <= LOAD;
                            end
                        end else begin
                            r_out_data <= r_shift[31:0];
                            r_shift    <= {32'b0, r_shift[BURST_W-1:32]};
                            r_widx     <= r_widx + IDX_W'(1);
`ifdef ADC_BURST_READER_CHECKSUM_EN
                            r_out_last <= 1'b0;
`else
                            // Counter already reflects this burst's pop.
                            r_out_last <= ((r_widx + IDX_W'(1)) == LAST_IDX) && w_at_zero;
`endif
                        end
                    end
                end

`ifdef ADC_BURST_READER_CHECKSUM_EN
                TRAILER: begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
`endif

                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ADC_BURST_READER_CHECKSUM_EN
    // Running sum of every transferred header and payload word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum <= '0;
        end else if (w_start_acc) begin
            r_sum <= '0;
        end else if (w_xfer && (r_state != TRAILER)) begin
            r_sum <= r_sum + r_out_data;
        end
    end
`endif

    assign fifo_rd_en  = w_pop;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign busy        = r_busy;
    assign done        = r_done;
    assign bursts_left = w_count;

endmodule
